// File: rtl/jericalla_sequencer.sv
// jericalla_sequencer
// Issues a stored program of up to 16 instruction words to the jericalla datapath,
// one word per cycle. It captures the datapath result and counts zero flags, then
// pulses done when the run completes.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | bus carries NOP, program memory writable, waits for start
// RUN    | issues mem[pc] each non-held cycle, captures result/z_flag
// DONE   | bus carries NOP, done pulse for one cycle, back to IDLE
//
// Ports:
//   clk, rst                synchronous active-high reset
//   prog_we/addr/data       program memory write port (IDLE only)
//   start, length           run request and instruction count (clamped to 16)
//   hold                    stall: NOP on the bus, pc frozen
//   result, z_flag          combinational datapath outputs
//   instruction             17-bit instruction bus
//   busy, done, pc          status
//   last_result, zero_count run results
module jericalla_sequencer #(
    parameter int MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [16:0] prog_data,
    input  logic        start,
    input  logic [4:0]  length,
    input  logic        hold,
    input  logic [31:0] result,
    input  logic        z_flag,
    output logic [16:0] instruction,
    output logic        busy,
    output logic        done,
    output logic [3:0]  pc,
    output logic [31:0] last_result,
    output logic [4:0]  zero_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    state_t      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] last_result_q, last_result_d;
    logic [4:0]  zero_count_q, zero_count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [16:0] mem_q [MAX_LEN];
    logic        mem_we;
    logic        issue;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        len_d         = len_q;
        last_result_d = last_result_q;
        zero_count_d  = zero_count_q;
        mem_we        = 1'b0;
        issue         = (state_q == S_RUN) && !hold;

        case (state_q)
            S_IDLE: begin
                mem_we = prog_we;
                if (start) begin
                    len_d        = (length > LEN_MAX) ? LEN_MAX : length;
                    pc_d         = 4'd0;
                    zero_count_d = 5'd0;
                    state_d      = (len_d == 5'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    last_result_d = result;
                    zero_count_d  = zero_count_q + {4'd0, z_flag};
                    // Stop on the last index so pc never wraps past 15.
                    if ({1'b0, pc_q} == (len_q - 5'd1)) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= 4'd0;
            len_q         <= 5'd0;
            last_result_q <= 32'd0;
            zero_count_q  <= 5'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            last_result_q <= last_result_d;
            zero_count_q  <= zero_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Program memory survives reset so a program can be replayed after an abort.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // The bus follows hold in the same cycle, so it is decoded from the current state.
    always_comb begin
        instruction = 17'd0;
        if (issue) begin
            instruction = mem_q[pc_q];
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pc          = pc_q;
    assign last_result = last_result_q;
    assign zero_count  = zero_count_q;

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Testbench for jericalla_sequencer. A stand-in datapath derives result and z_flag
// from the instruction bus: result = instruction + 0x1000_0000, z_flag = ~instruction[1].
module tb_jericalla_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [16:0] prog_data;
    logic        start;
    logic [4:0]  length;
    logic        hold;
    logic [31:0] result;
    logic        z_flag;
    logic [16:0] instruction;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [31:0] last_result;
    logic [4:0]  zero_count;

    int checks   = 0;
    int failures = 0;

    jericalla_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .length      (length),
        .hold        (hold),
        .result      (result),
        .z_flag      (z_flag),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .pc          (pc),
        .last_result (last_result),
        .zero_count  (zero_count)
    );

    always #5 clk = ~clk;

    assign result = {15'd0, instruction} + 32'h1000_0000;
    assign z_flag = ~instruction[1];

    typedef struct {
        logic        start;
        logic [4:0]  length;
        logic        hold;
        logic [16:0] exp_instr;
        logic        exp_busy;
        logic        exp_done;
        logic [3:0]  exp_pc;
        logic        chk_pc;
        logic [4:0]  exp_zc;
        logic        chk_zc;
        logic [31:0] exp_lr;
        logic        chk_lr;
    } vec_t;

    vec_t vecs[$];
    logic [16:0] words [16];

    function automatic vec_t mk(logic s, logic [4:0] l, logic h, logic [16:0] i,
                                logic b, logic d, logic [3:0] p, logic cp,
                                logic [4:0] zc, logic czc, logic [31:0] lr, logic clr);
        vec_t r;
        r.start = s; r.length = l; r.hold = h; r.exp_instr = i;
        r.exp_busy = b; r.exp_done = d; r.exp_pc = p; r.chk_pc = cp;
        r.exp_zc = zc; r.chk_zc = czc; r.exp_lr = lr; r.chk_lr = clr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [16:0] d);
        @(negedge clk);
        start = 1'b0; hold = 1'b0;
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    // Drives one cycle's inputs at the falling edge and settles before sampling.
    task automatic tick(input logic s, input logic [4:0] l, input logic h);
        @(negedge clk);
        start = s; length = l; hold = h; prog_we = 1'b0;
        #1;
    endtask

    task automatic chk_cycle(input string name, input logic [16:0] i, input logic b,
                             input logic d);
        chk({name, ".instr"}, {15'd0, instruction}, {15'd0, i});
        chk({name, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({name, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    initial begin
        int zc_exp;
        rst = 1'b1; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 17'd0;
        start = 1'b0; length = 5'd0; hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.instr", {15'd0, instruction}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.pc", {28'd0, pc}, 32'd0);
        chk("rst.last_result", last_result, 32'd0);
        chk("rst.zero_count", {27'd0, zero_count}, 32'd0);

        load(4'd0, 17'h00003);
        load(4'd1, 17'h02045);
        load(4'd2, 17'h0A0C7);

        // Basic run, hold mid-run, empty run (with a start during DONE that must be ignored).
        vecs.push_back(mk(1, 3, 0, 17'h00000, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 17'h00003, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 17'h02045, 1, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 17'h0A0C7, 1, 0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 17'h00000, 1, 1, 0, 0, 1, 1, 32'h1000A0C7, 1));
        vecs.push_back(mk(0, 0, 0, 17'h00000, 0, 0, 0, 0, 1, 1, 32'h1000A0C7, 1));
        vecs.push_back(mk(1, 3, 0, 17'h00000, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 17'h00003, 1, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 17'h00000, 1, 0, 1, 1, 0, 1, 32'h10000003, 1));
        vecs.push_back(mk(0, 0, 0, 17'h02045, 1, 0, 1, 1, 0, 1, 32'h10000003, 1));
        vecs.push_back(mk(0, 0, 0, 17'h0A0C7, 1, 0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 17'h00000, 1, 1, 0, 0, 1, 1, 32'h1000A0C7, 1));
        vecs.push_back(mk(0, 0, 0, 17'h00000, 0, 0, 0, 0, 1, 1, 32'h1000A0C7, 1));
        vecs.push_back(mk(1, 0, 0, 17'h00000, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 0, 17'h00000, 1, 1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 17'h00000, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 17'h00000, 0, 0, 0, 1, 0, 1, 0, 0));

        foreach (vecs[n]) begin
            string tag;
            tag = $sformatf("vec%0d", n);
            tick(vecs[n].start, vecs[n].length, vecs[n].hold);
            chk_cycle(tag, vecs[n].exp_instr, vecs[n].exp_busy, vecs[n].exp_done);
            if (vecs[n].chk_pc) chk({tag, ".pc"}, {28'd0, pc}, {28'd0, vecs[n].exp_pc});
            if (vecs[n].chk_zc) chk({tag, ".zc"}, {27'd0, zero_count}, {27'd0, vecs[n].exp_zc});
            if (vecs[n].chk_lr) chk({tag, ".lr"}, last_result, vecs[n].exp_lr);
        end

        // length = 20 clamps to a full 16-instruction run.
        zc_exp = 0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] i4;
            i4 = 4'(i);
            words[i] = {i4, ~i4, i4 + 4'd1, i4, 1'b1};
            if (i4[0] == 1'b0) zc_exp++;
            load(i4, words[i]);
        end
        tick(1, 20, 0);
        chk_cycle("len20.c0", 17'd0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            tick(0, 0, 0);
            chk_cycle($sformatf("len20.c%0d", k + 1), words[k], 1, 0);
            chk($sformatf("len20.pc%0d", k), {28'd0, pc}, k);
        end
        tick(0, 0, 0);
        chk_cycle("len20.c17", 17'd0, 1, 1);
        chk("len20.zc", {27'd0, zero_count}, zc_exp);
        chk("len20.lr", last_result, {15'd0, words[15]} + 32'h1000_0000);
        tick(0, 0, 0);
        chk_cycle("len20.c18", 17'd0, 0, 0);

        // start and prog_we during RUN are ignored.
        tick(1, 4, 0);
        tick(0, 0, 0);
        chk_cycle("ign.c1", words[0], 1, 0);
        @(negedge clk);
        start = 1'b1; length = 5'd1; prog_we = 1'b1; prog_addr = 4'd1; prog_data = 17'h1FFFF;
        #1;
        chk_cycle("ign.c2", words[1], 1, 0);
        tick(0, 0, 0);
        chk_cycle("ign.c3", words[2], 1, 0);
        chk("ign.pc3", {28'd0, pc}, 32'd2);
        tick(0, 0, 0);
        chk_cycle("ign.c4", words[3], 1, 0);
        tick(0, 0, 0);
        chk_cycle("ign.c5", 17'd0, 1, 1);
        tick(0, 0, 0);
        tick(1, 2, 0);
        tick(0, 0, 0);
        chk_cycle("rdbk.c1", words[0], 1, 0);
        tick(0, 0, 0);
        chk_cycle("rdbk.c2", words[1], 1, 0);
        tick(0, 0, 0);
        chk_cycle("rdbk.c3", 17'd0, 1, 1);
        tick(0, 0, 0);

        // Simultaneous start and write: the run sees the new word.
        @(negedge clk);
        start = 1'b1; length = 5'd1; hold = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 17'h15555;
        #1;
        tick(0, 0, 0);
        chk_cycle("simul.c1", 17'h15555, 1, 0);
        tick(0, 0, 0);
        chk_cycle("simul.c2", 17'd0, 1, 1);
        tick(0, 0, 0);

        // Reset during cycle 2 of a 5-long run.
        tick(1, 5, 0);
        tick(0, 0, 0);
        chk_cycle("rmid.c1", 17'h15555, 1, 0);
        tick(0, 0, 0);
        rst = 1'b1;
        tick(0, 0, 0);
        rst = 1'b0;
        #1;
        chk_cycle("rmid.c3", 17'd0, 0, 0);
        chk("rmid.pc", {28'd0, pc}, 32'd0);
        chk("rmid.zc", {27'd0, zero_count}, 32'd0);
        chk("rmid.lr", last_result, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick(0, 0, 0);
            chk_cycle($sformatf("rmid.quiet%0d", k), 17'd0, 0, 0);
        end
        tick(1, 5, 0);
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 0);
            chk_cycle($sformatf("replay.c%0d", k + 1), (k == 0) ? 17'h15555 : words[k], 1, 0);
        end
        tick(0, 0, 0);
        chk_cycle("replay.c6", 17'd0, 1, 1);
        tick(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jericalla_sequencer.md
# jericalla_sequencer

Instruction sequencer that drives the 17-bit instruction bus of the single-cycle jericalla datapath. It holds a 16-entry program memory and issues a programmed run of instructions one per cycle after a start request. It gathers the datapath's `result` and `z_flag` and reports completion with a one-cycle done pulse. It sits between the test/control host and the datapath: the host loads and starts programs, and the datapath executes them.

## Interface
- `MAX_LEN`, 16: program memory depth (fixed; `pc` is 4 bits).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  program-memory write strobe, honoured only in IDLE.
- `prog_addr`  in  4  program-memory write address.
- `prog_data`  in  17  instruction word to store: [16:13] RAM address, [12:9] ALU select, [8:5] ROM address 1, [4:1] ROM address 2, [0] RAM write enable.
- `start`  in  1  run request, sampled only in IDLE.
- `length`  in  5  number of instructions to issue, captured with `start`. 0 means an empty run; values above 16 clamp to 16.
- `hold`  in  1  stall; in RUN, issues a NOP and freezes `pc`.
- `result`  in  32  datapath result.
- `z_flag`  in  1  datapath zero flag.
- `instruction`  out  17  instruction to the datapath.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at run completion.
- `pc`  out  4  index of the instruction currently issued.
- `last_result`  out  32  `result` captured on the last issued instruction.
- `zero_count`  out  5  number of issued instructions with `z_flag`=1 in the current/last run.

## Operation
- **States:**
  - IDLE: `instruction` = 17'd0, which is a NOP because bit 0 = 0 means no RAM write.
    - `prog_we` writes `prog_data` into `mem[prog_addr]`.
    - `start` captures `len = min(length, 16)`, clears `pc` and `zero_count`, and goes to RUN. If `len` = 0, it goes directly to DONE.
  - RUN:
    - With `hold` = 0: `instruction` = `mem[pc]`. At the clock edge, `last_result` ← `result` and `zero_count` += `z_flag`. If `pc` = `len`−1, go to DONE; otherwise `pc` += 1.
    - With `hold` = 1: `instruction` = 17'd0, and nothing is captured or advanced.
  - DONE: `instruction` = 17'd0 and `done` = 1. Go to IDLE next cycle.
- **Ignored inputs:**
  - `start` outside IDLE is ignored (no queuing).
  - `prog_we` outside IDLE is ignored; program memory is read-only while running.
  - A simultaneous `start` and `prog_we` in IDLE both take effect. The run reads the memory contents after the write.
- **Width rules:** `zero_count` saturates at 16 by construction. `pc` never wraps within a run.
- **Reset:**
  - Effects: state = IDLE, `instruction` = 0, `busy` = 0, `done` = 0, `pc` = 0, `last_result` = 0, `zero_count` = 0.
  - Reset mid-run aborts at once, with no further issues and no `done` pulse.
  - Program memory is not cleared by reset.

## Timing
- A start seen at edge E₀ puts instruction 0 on the bus in the cycle after E₀. With no holds, instruction k is issued in cycle k+1.
- `done` is high in cycle `len`+1 (cycle 1 for `len` = 0). `busy` is high in cycles 1 through `len`+1.
- Each `hold` cycle in RUN adds exactly one cycle to the run.
- The datapath is combinational: `result` and `z_flag` are sampled at the edge ending the cycle in which their instruction is issued.
- `last_result` and `zero_count` are final and stable when `done` is high, and they hold until the next `start`.
- `done` is never asserted for two consecutive cycles. A `start` during DONE is ignored; the earliest accepted restart is the first IDLE cycle.

## Test plan
- **Basic run:** load `mem[0..2]` = 17'h00003, 17'h02045, 17'h0A0C7, then pulse `start` with `length` = 3.
  - Bus shows those words in cycles 1–3, then 0; `done` in cycle 4.
  - `last_result` equals the datapath result for 17'h0A0C7.
  - `zero_count` matches the number of z_flag=1 cycles.
- **Hold mid-run:** `length` = 3 with `hold` high in cycle 2.
  - Cycle 2 issues 0 with `pc` = 1 frozen; `done` moves to cycle 5.
- **Boundaries:**
  - `length` = 0: no instruction issued, `done` in cycle 1, `zero_count` = 0.
  - `length` = 20: exactly 16 issues (`pc` 0..15), `done` in cycle 17.
- **Ignored inputs:** `start` and `prog_we` asserted during RUN do not restart the run and leave memory unchanged; a readback run afterwards confirms the original words.
- **Reset mid-run:** `rst` at cycle 2 of a 5-long run.
  - Next cycle: `instruction` = 0, `busy` = 0, counters = 0, no `done`.
  - A new `start` replays the retained program.
